bcd_mod_counter: RTL
====================

Name: bcd_mod_counter

Overview:
- Parametrised BCD modulo-N counter for the digital clock datapath. It generalises the fixed mod-60 seconds/minutes counter to any modulus and digit count, adding enable, up/down, parallel load and cascadable carry/borrow.
- Instances are chained to build the clock: seconds (MOD=60), minutes (MOD=60) and hours (MOD=24 or 12). Each stage's co drives the next stage's en.

Parameters:
- NDIG, 2, number of BCD digits; q width = 4*NDIG; legal range 1..4.
- MOD, 60, count modulus; the count sequence is 0..MOD-1; legal range 2..10**NDIG; an illegal value is an elaboration error.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- en  in  1  count enable (carry-in from the previous stage or the 1 Hz tick)
- up  in  1  direction: 1 = increment, 0 = decrement
- load  in  1  parallel load strobe
- din  in  4*NDIG  BCD value to load, with digit 0 (units) in din[3:0]
- q  out  4*NDIG  current count in BCD, with digit 0 in q[3:0]
- tc  out  1  terminal count, combinational: (up && q==MOD-1) || (!up && q==0)
- co  out  1  cascade carry/borrow, combinational: en && tc
- load_err  out  1  registered one-cycle pulse when a load is rejected

Behaviour:
- Reset is synchronous and active-high: on a clk edge with rst=1, q=0 and load_err=0. tc and co follow from q=0.
- Priority on each edge is rst > load > en. With none of them asserted, q holds.
- Load, valid case: din is valid when every digit is ≤9 and its decimal value is <MOD. Then q=din on the same edge (1-cycle latency) and load_err=0. en is ignored that cycle.
- Load, invalid case: q holds its value and load_err=1 for exactly one cycle. Back-to-back invalid loads hold load_err high.
- load_err is 0 on every cycle that has no invalid load.
- Increment (en=1, up=1):
  - q==MOD-1 wraps to 0.
  - Otherwise, add 1 in BCD with a ripple carry between digits: a digit 9 becomes 0 and carries into the next digit.
- Decrement (en=1, up=0):
  - q==0 wraps to MOD-1 in BCD.
  - Otherwise, subtract 1 in BCD with a ripple borrow: a digit 0 becomes 9 and borrows from the next digit.
- co is combinational, so a downstream stage advances on the same edge that wraps this stage. There is no extra latency through a chain of stages.
- up may change on any cycle. tc and co re-evaluate immediately, and the next edge uses the new direction.
- rst asserted mid-count overrides en and load on that edge. A load or increment on that edge is lost.
- q never leaves the set {0..MOD-1} with all digits ≤9 after reset. A bench assertion must check this every cycle.
- There are no internal dividers and no asynchronous logic; all state is registered on clk.

Decomposition:
- Package bcd_pkg holds:
  - constant BCD_W=4;
  - function is_bcd_digit;
  - function bcd_to_int, for the load range check and bench use;
  - function int_to_bcd, for the MOD-1 constant.
- Sub-module bcd_digit is one decade, generated NDIG times.
  - Ports: clk, rst, ld, d, inc, dec, clr_to, ci, q, co_dig.
  - It handles the per-digit 9→0 and 0→9 ripple.
  - The top level handles the modulus wrap, by forcing the values 0 or MOD-1 through a per-digit preset, and does the load validation.

Test Plan:
- Reset and count: rst=1 for 5 cycles then 0, en=1, up=1, MOD=60. q is 8'h00 at the reset edge, then 01, 02 … 09, 10. At q=8'h59, tc=1 and co=1 in that cycle, and the next edge gives q=8'h00.
- Decrement wrap: load din=8'h01, then en=1, up=0. q goes 01 → 00 (co=1 in that cycle) → 59 → 58. On the 10→09 edge, the digit borrow gives q=8'h09.
- Invalid loads: with q=8'h23, load din=8'h60 (≥MOD), then din=8'h3A (non-BCD digit). q stays 8'h23 and load_err=1 on each cycle. Next, a valid load of din=8'h45 gives q=8'h45 and load_err=0.
- Priority: assert rst=1, load=1 (din=8'h30) and en=1 on the same edge, and q=8'h00. Then assert load=1 and en=1 (din=8'h30), and q=8'h30, not 8'h31.
- Cascade: chain sec(MOD=60) → min(MOD=60) → hr(NDIG=2, MOD=24) and preset 23:59:59. One en pulse gives 00:00:00 on a single edge, with all three co outputs high in the preceding cycle.
- Generic parameters: NDIG=3, MOD=100, up, start at 12'h098. The sequence is 099 → 000, and the sequence never reaches 100 at any point. Also run NDIG=1, MOD=7: the sequence is 0..6 then wraps to 0.

Source files
------------

// File: rtl/bcd_pkg.sv
// BCD helpers shared by the counter, its digit slices and the bench.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package bcd_pkg;

    localparam int BCD_W    = 4;
    localparam int MAX_NDIG = 4;

    function automatic logic is_bcd_digit(input logic [BCD_W-1:0] d);
        return d <= 4'd9;
    endfunction

    // Digits above the counter width must be zero-filled by the caller.
    function automatic int bcd_to_int(input logic [BCD_W*MAX_NDIG-1:0] v);
        int r;
        r = 0;
        for (int i = MAX_NDIG - 1; i >= 0; i--) begin
            r = r * 10 + int'(v[BCD_W*i +: BCD_W]);
        end
        return r;
    endfunction

    function automatic logic [BCD_W*MAX_NDIG-1:0] int_to_bcd(input int v);
        logic [BCD_W*MAX_NDIG-1:0] r;
        int t;
        r = '0;
        t = v;
        for (int i = 0; i < MAX_NDIG; i++) begin
            r[BCD_W*i +: BCD_W] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade: load/preset, ripple increment (9->0) and ripple decrement (0->9).
// Latency: 1 cycle from strobe to q; co_dig is combinational from ci and q.
// Backpressure: none; the digit only moves when ci is high.
module bcd_digit
    import bcd_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic [BCD_W-1:0] d,
    input  logic             inc,
    input  logic             dec,
    input  logic             clr_to,
    input  logic             ci,
    output logic [BCD_W-1:0] q,
    output logic             co_dig
);

    always_comb begin
        co_dig = ci && ((inc && q == 4'd9) || (dec && q == 4'd0));
    end

    // clr_to forces the whole word to its modulus-wrap value regardless of ci.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (ld || clr_to) begin
            q <= d;
        end else if (ci && inc) begin
            q <= (q == 4'd9) ? 4'd0 : q + 4'd1;
        end else if (ci && dec) begin
            q <= (q == 4'd0) ? 4'd9 : q - 4'd1;
        end
    end

endmodule

// File: rtl/bcd_mod_counter.sv
// Cascadable BCD modulo-MOD up/down counter with validated parallel load.
// Latency: 1 cycle for count/load; tc and co are combinational for zero-lag chaining.
// Backpressure: none; en gates counting, load takes precedence over en.
module bcd_mod_counter
    import bcd_pkg::*;
#(
    parameter int NDIG = 2,
    parameter int MOD  = 60
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [BCD_W*NDIG-1:0] din,
    output logic [BCD_W*NDIG-1:0] q,
    output logic                  tc,
    output logic                  co,
    output logic                  load_err
);

    localparam int W = BCD_W * NDIG;
    localparam logic [BCD_W*MAX_NDIG-1:0] MAX_FULL = int_to_bcd(MOD - 1);
    localparam logic [W-1:0]              MAX_BCD  = MAX_FULL[W-1:0];

    generate
        if (NDIG < 1 || NDIG > MAX_NDIG || MOD < 2 || MOD > 10**NDIG) begin : g_bad_param
            $error("bcd_mod_counter: illegal NDIG/MOD combination");
        end
    endgenerate

    logic                        din_ok;
    logic [BCD_W*MAX_NDIG-1:0]   din_full;
    logic                        step;
    logic                        wrap;
    logic                        ld_ok;
    logic [W-1:0]                wrap_val;
    logic [NDIG:0]               carry;
    logic                        unused_carry;

    always_comb begin
        din_full        = '0;
        din_full[W-1:0] = din;
        din_ok          = 1'b1;
        for (int i = 0; i < NDIG; i++) begin
            if (!is_bcd_digit(din[BCD_W*i +: BCD_W])) din_ok = 1'b0;
        end
        if (bcd_to_int(din_full) >= MOD) din_ok = 1'b0;
    end

    assign tc       = up ? (q == MAX_BCD) : (q == '0);
    assign co       = en && tc;
    assign step     = en && !load;
    assign wrap     = step && tc;
    assign ld_ok    = load && din_ok;
    assign wrap_val = up ? '0 : MAX_BCD;
    assign carry[0] = step;
    // The top digit's ripple-out is subsumed by the modulus wrap.
    assign unused_carry = carry[NDIG];

    generate
        for (genvar g = 0; g < NDIG; g++) begin : g_dig
            bcd_digit u_dig (
                .clk    (clk),
                .rst    (rst),
                .ld     (ld_ok),
                .d      (load ? din[BCD_W*g +: BCD_W] : wrap_val[BCD_W*g +: BCD_W]),
                .inc    (up),
                .dec    (!up),
                .clr_to (wrap),
                .ci     (carry[g]),
                .q      (q[BCD_W*g +: BCD_W]),
                .co_dig (carry[g+1])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            load_err <= 1'b0;
        end else begin
            load_err <= load && !din_ok;
        end
    end

endmodule
